// File: rtl/key_pkg.sv
// Shared types and constants for the key-gesture blocks: FSM state encoding
// and the millisecond-to-cycle conversion used to size prescalers.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP,
        WAIT_REL
    } key_state_t;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running prescaler emitting one-cycle ticks every PERIOD cycles;
// clr restarts the period so the next tick lands a full PERIOD later.
module ms_tick #(
    parameter int PERIOD = 65_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/key_event.sv
// Key-gesture classifier: short press, long press and double click pulses.
// Build option: define KEY_EVENT_REPEAT_EN to re-emit olong every REPEAT_MS while held.
module key_event
    import key_pkg::*;
#(
    parameter int CLK_FREQ     = 65_000_000,
    parameter int LONG_MS      = 1000,
    parameter int GAP_MS       = 250,
    parameter int REPEAT_MS    = 100,
    parameter bit ACTIVE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ikey,
    input  logic ivalid,
    output logic oshort,
    output logic olong,
    output logic odouble,
    output logic oheld
);

    localparam int TICK_CYC = ms_to_cycles(CLK_FREQ, 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam int MS_MAX = max_of(max_of(LONG_MS, GAP_MS), REPEAT_MS);
`else
    localparam int MS_MAX = max_of(LONG_MS, GAP_MS) + 0 * REPEAT_MS;
`endif
    localparam int MS_W = $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] LONG_CNT = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] GAP_CNT  = MS_W'(GAP_MS);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [MS_W-1:0] REP_CNT  = MS_W'(REPEAT_MS);
`endif

    key_state_t      state;
    key_state_t      state_nxt;
    logic            lvl;
    logic            is_act;
    logic            press;
    logic            key_rel;
    logic            tick;
    logic            clr;
    logic            rep_clr;
    logic            short_nxt;
    logic            long_nxt;
    logic            dbl_nxt;
    logic [MS_W-1:0] ms_cnt;

    assign is_act  = (ikey == ACTIVE_LEVEL);
    assign press   = ivalid & is_act & (lvl != ACTIVE_LEVEL);
    assign key_rel = ivalid & ~is_act & (lvl == ACTIVE_LEVEL);
    // Every state change (and each auto-repeat) restarts the ms timebase.
    assign clr     = (state_nxt != state) | rep_clr;

    ms_tick #(
        .PERIOD(TICK_CYC)
    ) u_ms_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    // Edges are tested before timeouts so a coincident edge suppresses the pulse.
    always_comb begin
        state_nxt = state;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        dbl_nxt   = 1'b0;
        rep_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (press) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (key_rel) begin
                    state_nxt = WAIT_GAP;
                end else if (ms_cnt == LONG_CNT) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (key_rel) begin
                    state_nxt = IDLE;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (ms_cnt == REP_CNT) begin
                    long_nxt = 1'b1;
                    rep_clr  = 1'b1;
                end
`endif
            end
            WAIT_GAP: begin
                if (press) begin
                    dbl_nxt   = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (ms_cnt == GAP_CNT) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (key_rel) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lvl     <= ~ACTIVE_LEVEL;
            ms_cnt  <= '0;
            oshort  <= 1'b0;
            olong   <= 1'b0;
            odouble <= 1'b0;
            oheld   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ivalid) lvl <= ikey;
            if (clr) begin
                ms_cnt <= '0;
            end else if (tick && (ms_cnt != '1)) begin
                ms_cnt <= ms_cnt + MS_W'(1);
            end
            oshort  <= short_nxt;
            olong   <= long_nxt;
            odouble <= dbl_nxt;
            oheld   <= (state_nxt inside {PRESSED, LONG_HELD, WAIT_REL});
        end
    end

endmodule
